// File: rtl/apb_rr_scheduler_pkg.sv
// Shared types for the APB round-robin scheduler.
package apb_rr_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS
  } apb_sched_state_t;

endpackage

// File: rtl/apb_rr_scheduler_if.sv
// Requester-side and APB-side signal bundle of the scheduler; master is the scheduler view.
interface apb_rr_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
);

  logic [NUM_REQ-1:0]             req_i;
  logic [NUM_REQ-1:0]             req_write_i;
  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr_i;
  logic [NUM_REQ-1:0][DATA_W-1:0] req_wdata_i;
  logic [NUM_REQ-1:0]             gnt_o;
  logic [NUM_REQ-1:0]             done_o;
  logic [DATA_W-1:0]              rdata_o;
  logic                           err_o;
  logic                           timeout_o;

  logic                           psel_o;
  logic                           penable_o;
  logic [ADDR_W-1:0]              paddr_o;
  logic                           pwrite_o;
  logic [DATA_W-1:0]              pwdata_o;
  logic [DATA_W-1:0]              prdata_i;
  logic                           pready_i;
  logic                           pslverr_i;

  modport master (
    input  req_i, req_write_i, req_addr_i, req_wdata_i, prdata_i, pready_i, pslverr_i,
    output gnt_o, done_o, rdata_o, err_o, timeout_o,
           psel_o, penable_o, paddr_o, pwrite_o, pwdata_o
  );

  modport slave (
    output req_i, req_write_i, req_addr_i, req_wdata_i, prdata_i, pready_i, pslverr_i,
    input  gnt_o, done_o, rdata_o, err_o, timeout_o,
           psel_o, penable_o, paddr_o, pwrite_o, pwdata_o
  );

endinterface

// File: rtl/apb_rr_scheduler_rr_arbiter.sv
// Round-robin pick: first set request at/after ptr, wrapping. One-hot grant plus index.
// Latency 0 (pure combinational); no backpressure, vld low when nothing requests.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          vld
);

  always_comb begin
    gnt = '0;
    idx = '0;
    vld = 1'b0;
    for (int i = 0; i < N; i++) begin
      int j;
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      if (!vld && req[j]) begin
        vld    = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/apb_rr_scheduler.sv
// Shares one APB completer between NUM_REQ requesters, round-robin, with PREADY timeout.
// Min 3 cycles per transfer (SETUP, ACCESS, IDLE); requests held off until the IDLE cycle.
module apb_rr_scheduler
  import apb_rr_scheduler_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic pclk,
  input  logic preset_n,
  apb_rr_scheduler_if.master bus
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT + 1);

  apb_sched_state_t state;
  logic [IW-1:0]      ptr_q;
  logic [IW-1:0]      idx_q;
  logic [CW-1:0]      cnt_q;
  logic [NUM_REQ-1:0] arb_gnt;
  logic [IW-1:0]      arb_idx;
  logic               arb_vld;
  logic [IW-1:0]      ptr_nxt;
  logic               xfer_end;

  rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_arb (
    .req (bus.req_i),
    .ptr (ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .vld (arb_vld)
  );

  assign ptr_nxt  = (idx_q == IW'(NUM_REQ - 1)) ? '0 : idx_q + IW'(1);
  // cnt_q holds the number of the current ACCESS cycle, so abort on the TIMEOUT-th one
  assign xfer_end = bus.pready_i || (cnt_q == CW'(TIMEOUT));

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state         <= ST_IDLE;
      ptr_q         <= '0;
      idx_q         <= '0;
      cnt_q         <= '0;
      bus.gnt_o     <= '0;
      bus.done_o    <= '0;
      bus.rdata_o   <= '0;
      bus.err_o     <= 1'b0;
      bus.timeout_o <= 1'b0;
      bus.psel_o    <= 1'b0;
      bus.penable_o <= 1'b0;
      bus.paddr_o   <= '0;
      bus.pwrite_o  <= 1'b0;
      bus.pwdata_o  <= '0;
    end else begin
      bus.done_o    <= '0;
      bus.rdata_o   <= '0;
      bus.err_o     <= 1'b0;
      bus.timeout_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (arb_vld) begin
            idx_q        <= arb_idx;
            bus.gnt_o    <= arb_gnt;
            bus.psel_o   <= 1'b1;
            bus.paddr_o  <= bus.req_addr_i[arb_idx];
            bus.pwrite_o <= bus.req_write_i[arb_idx];
            bus.pwdata_o <= bus.req_wdata_i[arb_idx];
            state        <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          bus.penable_o <= 1'b1;
          cnt_q         <= CW'(1);
          state         <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (xfer_end) begin
            bus.done_o    <= bus.gnt_o;
            bus.err_o     <= bus.pready_i ? bus.pslverr_i : 1'b1;
            bus.timeout_o <= !bus.pready_i;
            bus.rdata_o   <= (bus.pready_i && !bus.pwrite_o) ? bus.prdata_i : '0;
            ptr_q         <= ptr_nxt;
            bus.gnt_o     <= '0;
            bus.psel_o    <= 1'b0;
            bus.penable_o <= 1'b0;
            bus.paddr_o   <= '0;
            bus.pwrite_o  <= 1'b0;
            bus.pwdata_o  <= '0;
            state         <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_rr_scheduler.sv
// Directed bench for apb_rr_scheduler: single read, round robin, wait states, timeout,
// mid-transfer reset and mid-transfer request changes, against hand-computed values.
module tb_apb_rr_scheduler;

  localparam int NR = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  logic pclk     = 1'b0;
  logic preset_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  always #5 pclk = ~pclk;

  apb_rr_scheduler_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) bus ();

  apb_rr_scheduler #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .pclk     (pclk),
    .preset_n (preset_n),
    .bus      (bus)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req_i       = '0;
    bus.req_write_i = '0;
    bus.req_addr_i  = '0;
    bus.req_wdata_i = '0;
    bus.prdata_i    = '0;
    bus.pready_i    = 1'b0;
    bus.pslverr_i   = 1'b0;
  endtask

  task automatic do_reset();
    preset_n = 1'b0;
    repeat (2) tick();
    preset_n = 1'b1;
  endtask

  initial begin
    logic [NR-1:0] e;
    idle_inputs();
    #2;
    check_eq("rst_psel",    bus.psel_o,    0);
    check_eq("rst_penable", bus.penable_o, 0);
    check_eq("rst_gnt",     bus.gnt_o,     0);
    check_eq("rst_done",    bus.done_o,    0);
    check_eq("rst_paddr",   bus.paddr_o,   0);
    check_eq("rst_pwdata",  bus.pwdata_o,  0);
    check_eq("rst_rdata",   bus.rdata_o,   0);
    check_eq("rst_err",     bus.err_o,     0);
    check_eq("rst_timeout", bus.timeout_o, 0);
    repeat (2) tick();
    preset_n = 1'b1;

    // single read from requester 0
    bus.req_i         = 4'b0001;
    bus.req_addr_i[0] = 32'hA000;
    tick();
    check_eq("t1_setup_psel",    bus.psel_o,    1);
    check_eq("t1_setup_penable", bus.penable_o, 0);
    check_eq("t1_setup_paddr",   bus.paddr_o,   32'hA000);
    check_eq("t1_setup_pwrite",  bus.pwrite_o,  0);
    check_eq("t1_setup_gnt",     bus.gnt_o,     4'b0001);
    bus.req_i    = '0;
    bus.pready_i = 1'b1;
    bus.prdata_i = 32'hDEADBEEF;
    tick();
    check_eq("t1_acc_psel",    bus.psel_o,    1);
    check_eq("t1_acc_penable", bus.penable_o, 1);
    check_eq("t1_acc_done",    bus.done_o,    0);
    tick();
    check_eq("t1_done",  bus.done_o,  4'b0001);
    check_eq("t1_rdata", bus.rdata_o, 32'hDEADBEEF);
    check_eq("t1_err",   bus.err_o,   0);
    check_eq("t1_psel",  bus.psel_o,  0);
    check_eq("t1_gnt",   bus.gnt_o,   0);
    tick();
    check_eq("t1_done_pulse", bus.done_o, 0);
    idle_inputs();

    // round robin with all four requesting; reset puts the pointer back to 0
    do_reset();
    bus.req_i    = 4'b1111;
    bus.pready_i = 1'b1;
    for (int i = 0; i < NR; i++) bus.req_addr_i[i] = 32'h100 * i;
    for (int k = 0; k < 5; k++) begin
      e = 4'(1 << (k % 4));
      tick();
      check_eq($sformatf("t2_gnt%0d", k),   bus.gnt_o,     e);
      check_eq($sformatf("t2_paddr%0d", k), bus.paddr_o,   32'h100 * (k % 4));
      check_eq($sformatf("t2_setup%0d", k), bus.penable_o, 0);
      tick();
      check_eq($sformatf("t2_acc%0d", k),   bus.penable_o, 1);
      tick();
      check_eq($sformatf("t2_gap%0d", k),   bus.psel_o,    0);
      check_eq($sformatf("t2_done%0d", k),  bus.done_o,    e);
    end
    bus.req_i = '0;
    tick();
    check_eq("t2_quiet", bus.psel_o, 0);
    idle_inputs();

    // write with three wait states and a slave error
    do_reset();
    bus.req_i          = 4'b0100;
    bus.req_write_i[2] = 1'b1;
    bus.req_addr_i[2]  = 32'h1234;
    bus.req_wdata_i[2] = 32'hCAFE0001;
    bus.pslverr_i      = 1'b1;
    tick();
    check_eq("t3_gnt",    bus.gnt_o,    4'b0100);
    check_eq("t3_pwrite", bus.pwrite_o, 1);
    check_eq("t3_pwdata", bus.pwdata_o, 32'hCAFE0001);
    bus.req_i = '0;
    for (int w = 1; w <= 4; w++) begin
      tick();
      check_eq($sformatf("t3_psel_w%0d", w),    bus.psel_o,    1);
      check_eq($sformatf("t3_penable_w%0d", w), bus.penable_o, 1);
      check_eq($sformatf("t3_paddr_w%0d", w),   bus.paddr_o,   32'h1234);
      check_eq($sformatf("t3_done_w%0d", w),    bus.done_o,    0);
    end
    bus.pready_i = 1'b1;
    tick();
    check_eq("t3_done",  bus.done_o,    4'b0100);
    check_eq("t3_err",   bus.err_o,     1);
    check_eq("t3_rdata", bus.rdata_o,   0);
    check_eq("t3_to",    bus.timeout_o, 0);
    check_eq("t3_psel",  bus.psel_o,    0);
    idle_inputs();

    // timeout on requester 0 (pointer sits at 3, so the pick wraps), then requester 1
    bus.req_i         = 4'b0011;
    bus.req_addr_i[0] = 32'h2000;
    bus.req_addr_i[1] = 32'h2004;
    bus.prdata_i      = 32'h55AA55AA;
    tick();
    check_eq("t4_gnt_wrap", bus.gnt_o, 4'b0001);
    for (int c = 1; c <= TO; c++) begin
      tick();
      check_eq($sformatf("t4_wait_done%0d", c), bus.done_o,    0);
      check_eq($sformatf("t4_wait_en%0d", c),   bus.penable_o, 1);
    end
    tick();
    check_eq("t4_done",  bus.done_o,    4'b0001);
    check_eq("t4_err",   bus.err_o,     1);
    check_eq("t4_to",    bus.timeout_o, 1);
    check_eq("t4_rdata", bus.rdata_o,   0);
    check_eq("t4_psel",  bus.psel_o,    0);
    bus.pready_i = 1'b1;
    tick();
    check_eq("t4_next_gnt",  bus.gnt_o,     4'b0010);
    check_eq("t4_to_pulse",  bus.timeout_o, 0);
    check_eq("t4_next_addr", bus.paddr_o,   32'h2004);
    bus.req_i = '0;
    tick();
    tick();
    check_eq("t4_done2",  bus.done_o,  4'b0010);
    check_eq("t4_rdata2", bus.rdata_o, 32'h55AA55AA);
    check_eq("t4_err2",   bus.err_o,   0);
    idle_inputs();

    // reset in the middle of ACCESS
    bus.req_i         = 4'b1000;
    bus.req_addr_i[3] = 32'h3000;
    tick();
    check_eq("t5_gnt", bus.gnt_o, 4'b1000);
    tick();
    check_eq("t5_acc", bus.penable_o, 1);
    #2;
    preset_n = 1'b0;
    #1;
    check_eq("t5_psel_async",    bus.psel_o,    0);
    check_eq("t5_penable_async", bus.penable_o, 0);
    check_eq("t5_gnt_async",     bus.gnt_o,     0);
    bus.req_i = 4'b0100;
    tick();
    check_eq("t5_no_done", bus.done_o, 0);
    preset_n = 1'b1;
    tick();
    check_eq("t5_regnt",   bus.gnt_o,  4'b0100);
    check_eq("t5_no_done2", bus.done_o, 0);
    bus.req_i    = '0;
    bus.pready_i = 1'b1;
    tick();
    tick();
    check_eq("t5_done", bus.done_o, 4'b0100);
    idle_inputs();

    // request inputs altered mid-transfer must not reach the bus
    bus.req_i          = 4'b0001;
    bus.req_write_i[0] = 1'b1;
    bus.req_addr_i[0]  = 32'h0C00;
    bus.req_wdata_i[0] = 32'h11112222;
    tick();
    check_eq("t6_paddr_setup", bus.paddr_o, 32'h0C00);
    bus.req_i = '0;
    tick();
    bus.req_addr_i[0]  = 32'hFFFFFFFF;
    bus.req_wdata_i[0] = '0;
    bus.req_write_i[0] = 1'b0;
    tick();
    check_eq("t6_paddr_hold",  bus.paddr_o,  32'h0C00);
    check_eq("t6_pwdata_hold", bus.pwdata_o, 32'h11112222);
    check_eq("t6_pwrite_hold", bus.pwrite_o, 1);
    bus.pready_i = 1'b1;
    tick();
    check_eq("t6_done",  bus.done_o,  4'b0001);
    check_eq("t6_rdata", bus.rdata_o, 0);
    check_eq("t6_err",   bus.err_o,   0);
    idle_inputs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
